wam_ctrl: RTL and testbench
===========================

# wam_ctrl

Round controller for the whack-a-mole game. It sequences a timed round through idle, ready countdown, play, pause and game-over states. It drives the run enable and the clear for the mole generator and score counter, ramps the difficulty code during play, and keeps the session high score. It sits beside the generator/hit/score datapath under the game top level and replaces the raw start/pause wiring there.

## Interface
- `TICK_DIV`, 50_000_000: clk cycles per game second (1 s at 50 MHz).
- `GAME_SECS`, 60: round length in seconds, 1..99.
- `READY_SECS`, 3: pre-round countdown in seconds, 1..3.
- `LEVEL_SECS`, 15: play seconds per difficulty ramp step, ≥1.
- `clk` in 1: system clock.
- `clr_n` in 1: asynchronous active-low reset.
- `start` in 1: start button, already synchronised and debounced, level.
- `pause` in 1: pause button, already synchronised and debounced, level.
- `diff_sel` in 4: base difficulty from switches.
- `score` in 12: current score, 3-digit BCD from the score counter.
- `run` out 1: high only in PLAY; gates the generator's slow clock.
- `round_clr` out 1: one-cycle active-high clear to the generator and score counter.
- `hrdn` out 4: effective difficulty to the generator.
- `time_left` out 8: remaining seconds, 2-digit BCD.
- `ready_cnt` out 2: countdown value shown in READY.
- `game_over` out 1: high in OVER.
- `best` out 12: session high score, BCD.
- `state` out 3: IDLE=0, READY=1, PLAY=2, PAUSE=3, OVER=4.

## Operation
- **Input edges:** `start_e` and `pause_e` come from one-register rising-edge detectors. The first cycle after reset never produces an edge, because the detector registers reset to 1.
- **IDLE:**
  - `start_e` goes to READY.
  - `pause_e` is ignored.
- **READY:**
  - On entry: `ready_cnt`=READY_SECS, tick counter cleared, `diff_sel` latched into `base`, ramp cleared, `time_left`=GAME_SECS in BCD.
  - Each second tick decrements `ready_cnt`.
  - A tick while `ready_cnt`==1 goes to PLAY and sets `ready_cnt` to 0.
- **PLAY:**
  - Each second tick decrements `time_left` in BCD. The borrow from the ones digit goes to the tens digit: 0x10 becomes 0x09.
  - A tick while `time_left`==0x01 sets it to 0x00 and goes to OVER on the same edge.
  - Ramp step counter: every LEVEL_SECS ticks, `ramp` increments, saturating at 15.
  - `pause_e` goes to PAUSE.
- **PAUSE:**
  - Tick counter, `time_left` and ramp are frozen.
  - `pause_e` returns to PLAY, and the tick counter resumes from its held value.
- **OVER:**
  - On the entry edge, `best` is updated to `score` if `score` > `best`. Comparison is unsigned over the 12 bits, which is valid for BCD.
  - `start_e` goes to READY.
- **Restart:** `start_e` in READY, PLAY or PAUSE restarts the round by re-entering READY, with full entry actions.
- **Simultaneous edges:** when `start_e` and `pause_e` arrive together, start wins.
- **round_clr:** high for exactly the first cycle after any transition into READY, including READY to READY.
- **Difficulty:** `hrdn` = min(`base` + `ramp`, 15), computed with a 5-bit sum and saturated, registered.
- **Tick counter:**
  - Counts 0..TICK_DIV-1 only in READY and PLAY.
  - The tick is asserted on the cycle the counter equals TICK_DIV-1; the counter then wraps to 0.
  - Counter width is clog2(TICK_DIV).

## Timing
- **Reset values:**
  - `state`=IDLE, `run`=0, `round_clr`=0, `hrdn`=0, `time_left`=0x00, `ready_cnt`=0, `game_over`=0, `best`=0x000.
  - `best` is cleared only by `clr_n`.
- **Outputs:** all outputs are registered, and `run`/`game_over` change on the same edge as `state`.
- **Latencies:**
  - `start` rising to `state`=READY: 2 cycles (edge register plus state register). `round_clr` is high in the cycle `state` first reads READY.
  - READY to PLAY: READY_SECS×TICK_DIV cycles after READY entry.
  - PLAY entry to OVER: GAME_SECS×TICK_DIV cycles, excluding cycles spent in PAUSE.
- **Asynchronous reset mid-round:** immediate return to the reset values. The round is lost and `best` clears.
- **Held buttons:** a held `start` or `pause` produces one edge only.

## Test plan
Parameters for all scenarios: TICK_DIV=4, GAME_SECS=5, READY_SECS=3, LEVEL_SECS=2.

1. **Reset then start:** release `clr_n`, pulse `start`.
   - `round_clr` is high for 1 cycle.
   - `ready_cnt` steps 3→2→1 at 4-cycle intervals.
   - PLAY begins 12 cycles after READY entry with `time_left`=0x05 and `run`=1.
2. **Full round:** starting from scenario 1, run the round out.
   - `time_left` steps 05→04→03→02→01→00.
   - OVER is reached 20 cycles after PLAY entry, with `run`=0 and `game_over`=1.
   - With `score`=0x123, `best` becomes 0x123.
   - A second round with `score`=0x099 leaves `best`=0x123.
3. **Pause:** pause for 50 cycles mid-PLAY at `time_left`=0x03, then pause again.
   - `time_left` stays 0x03 and `run`=0 while paused.
   - After resume, OVER arrives exactly 50 cycles later than in scenario 2.
4. **Difficulty ramp:** `diff_sel`=13 at start.
   - `hrdn` is 13 at PLAY entry, 14 after 2 ticks, then saturates at 15 and stays there.
   - Changing `diff_sel` mid-round has no effect.
5. **Restart and simultaneous edges:** in PLAY, raise `start` and `pause` on the same cycle.
   - The controller goes to READY, not PAUSE.
   - `round_clr` pulses once.
   - `time_left` reloads to 0x05.
6. **BCD borrow and async reset:** set GAME_SECS=12, then assert `clr_n` low mid-PLAY.
   - `time_left` decrements 0x10→0x09 correctly.
   - The asynchronous reset forces `state`=IDLE and `best`=0 before the next clk edge.

Source files
------------

// File: rtl/wam_ctrl.sv
// Whack-a-mole round controller: sequences IDLE/READY/PLAY/PAUSE/OVER,
// drives the generator run/clear, ramps difficulty and keeps the session best.
module wam_ctrl #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int GAME_SECS  = 60,
    parameter int READY_SECS = 3,
    parameter int LEVEL_SECS = 15
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        start,
    input  logic        pause,
    input  logic [3:0]  diff_sel,
    input  logic [11:0] score,
    output logic        run,
    output logic        round_clr,
    output logic [3:0]  hrdn,
    output logic [7:0]  time_left,
    output logic [1:0]  ready_cnt,
    output logic        game_over,
    output logic [11:0] best,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READY = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int LCW = (LEVEL_SECS > 1) ? $clog2(LEVEL_SECS) : 1;
    localparam logic [TCW-1:0] TICK_MAX   = TCW'(TICK_DIV - 1);
    localparam logic [LCW-1:0] LEVEL_MAX  = LCW'(LEVEL_SECS - 1);
    localparam logic [7:0]     GAME_BCD   = {4'(GAME_SECS / 10), 4'(GAME_SECS % 10)};
    localparam logic [1:0]     READY_INIT = 2'(READY_SECS);

    // Two-digit BCD decrement; a zero ones digit borrows from the tens digit.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] res;
        if (v[3:0] == 4'd0) begin
            res = {v[7:4] - 4'd1, 4'd9};
        end else begin
            res = {v[7:4], v[3:0] - 4'd1};
        end
        return res;
    endfunction

    function automatic logic [3:0] sat_add(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[4] ? 4'hF : sum[3:0];
    endfunction

    state_t         r_state, w_next_state;
    logic           r_start_d, r_pause_d, r_start_e, r_pause_e;
    logic [TCW-1:0] r_tcnt;
    logic [LCW-1:0] r_lvl;
    logic [1:0]     r_ready_cnt;
    logic [7:0]     r_time_left;
    logic [3:0]     r_base, r_ramp, r_hrdn;
    logic [11:0]    r_best;
    logic           r_run, r_game_over, r_round_clr;
    logic           w_tick, w_enter_ready, w_enter_over, w_run_nx, w_over_nx;

    assign w_tick = ((r_state == S_READY) || (r_state == S_PLAY)) && (r_tcnt == TICK_MAX);

    // Registered edge detectors; the delay flops reset high so a button held through reset is not an edge.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_start_d <= 1'b1;
            r_pause_d <= 1'b1;
            r_start_e <= 1'b0;
            r_pause_e <= 1'b0;
        end else begin
            r_start_d <= start;
            r_pause_d <= pause;
            r_start_e <= start & ~r_start_d;
            r_pause_e <= pause & ~r_pause_d;
        end
    end

    // State register, with run/game_over moving on the same edge as the state.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state     <= S_IDLE;
            r_run       <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_run       <= w_run_nx;
            r_game_over <= w_over_nx;
        end
    end

    // Next-state logic; a start edge restarts the round from any state and beats pause.
    always_comb begin
        w_next_state = r_state;
        if (r_start_e) begin
            w_next_state = S_READY;
        end else begin
            case (r_state)
                S_IDLE:  w_next_state = S_IDLE;
                S_READY: w_next_state = (w_tick && (r_ready_cnt == 2'd1)) ? S_PLAY : S_READY;
                S_PLAY: begin
                    if (w_tick && (r_time_left == 8'h01)) begin
                        w_next_state = S_OVER;
                    end else if (r_pause_e) begin
                        w_next_state = S_PAUSE;
                    end else begin
                        w_next_state = S_PLAY;
                    end
                end
                S_PAUSE: w_next_state = r_pause_e ? S_PLAY : S_PAUSE;
                S_OVER:  w_next_state = S_OVER;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Output decode feeding the registered outputs and round-entry actions.
    always_comb begin
        w_run_nx      = (w_next_state == S_PLAY);
        w_over_nx     = (w_next_state == S_OVER);
        w_enter_ready = r_start_e;
        w_enter_over  = (r_state != S_OVER) && (w_next_state == S_OVER);
    end

    // Round datapath: second ticks, countdowns, difficulty ramp and high score.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_tcnt      <= '0;
            r_lvl       <= '0;
            r_ready_cnt <= 2'd0;
            r_time_left <= 8'h00;
            r_base      <= 4'd0;
            r_ramp      <= 4'd0;
            r_hrdn      <= 4'd0;
            r_best      <= 12'h000;
            r_round_clr <= 1'b0;
        end else begin
            r_round_clr <= w_enter_ready;
            r_hrdn      <= sat_add(r_base, r_ramp);
            if (w_enter_ready) begin
                r_tcnt      <= '0;
                r_lvl       <= '0;
                r_ready_cnt <= READY_INIT;
                r_time_left <= GAME_BCD;
                r_base      <= diff_sel;
                r_ramp      <= 4'd0;
            end else begin
                if ((r_state == S_READY) || (r_state == S_PLAY)) begin
                    r_tcnt <= w_tick ? '0 : r_tcnt + TCW'(1);
                end else begin
                    r_tcnt <= r_tcnt;
                end
                if ((r_state == S_READY) && w_tick) begin
                    r_ready_cnt <= r_ready_cnt - 2'd1;
                end else begin
                    r_ready_cnt <= r_ready_cnt;
                end
                if ((r_state == S_PLAY) && w_tick) begin
                    r_time_left <= bcd_dec(r_time_left);
                    if (r_lvl == LEVEL_MAX) begin
                        r_lvl  <= '0;
                        r_ramp <= (r_ramp == 4'hF) ? 4'hF : r_ramp + 4'd1;
                    end else begin
                        r_lvl  <= r_lvl + LCW'(1);
                    end
                end else begin
                    r_time_left <= r_time_left;
                end
            end
            if (w_enter_over && (score > r_best)) begin
                r_best <= score;
            end else begin
                r_best <= r_best;
            end
        end
    end

    assign run       = r_run;
    assign round_clr = r_round_clr;
    assign hrdn      = r_hrdn;
    assign time_left = r_time_left;
    assign ready_cnt = r_ready_cnt;
    assign game_over = r_game_over;
    assign best      = r_best;
    assign state     = r_state;

endmodule

// File: tb/tb_wam_ctrl.sv
// Directed bench for wam_ctrl with short game seconds; a second instance uses a
// 12-second round to exercise the BCD tens borrow.
module tb_wam_ctrl;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [3:0]  diff_sel = 4'd0;
    logic [11:0] score = 12'h000;

    logic        run, round_clr, game_over;
    logic [3:0]  hrdn;
    logic [7:0]  time_left;
    logic [1:0]  ready_cnt;
    logic [11:0] best;
    logic [2:0]  state;

    logic        run_12, round_clr_12, game_over_12;
    logic [3:0]  hrdn_12;
    logic [7:0]  time_left_12;
    logic [1:0]  ready_cnt_12;
    logic [11:0] best_12;
    logic [2:0]  state_12;

    int n_cmp = 0;
    int n_err = 0;

    wam_ctrl #(.TICK_DIV(4), .GAME_SECS(5), .READY_SECS(3), .LEVEL_SECS(2)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .pause(pause),
        .diff_sel(diff_sel), .score(score),
        .run(run), .round_clr(round_clr), .hrdn(hrdn), .time_left(time_left),
        .ready_cnt(ready_cnt), .game_over(game_over), .best(best), .state(state)
    );

    wam_ctrl #(.TICK_DIV(4), .GAME_SECS(12), .READY_SECS(3), .LEVEL_SECS(2)) dut12 (
        .clk(clk), .clr_n(clr_n), .start(start), .pause(pause),
        .diff_sel(diff_sel), .score(score),
        .run(run_12), .round_clr(round_clr_12), .hrdn(hrdn_12), .time_left(time_left_12),
        .ready_cnt(ready_cnt_12), .game_over(game_over_12), .best(best_12), .state(state_12)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench one cycle into READY (the round_clr cycle).
    task automatic press_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset();
        start = 1'b1;
        cyc(2);
        n_cmp++; if ({run, round_clr, hrdn, time_left, ready_cnt, game_over, best, state} !== 32'd0) begin
            n_err++; $display("FAIL reset_vals: got %h want 0", {run, round_clr, hrdn, time_left, ready_cnt, game_over, best, state}); end
        clr_n = 1'b1;
        cyc(3);
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL held_start_no_edge: got %0d want 0", state); end
        start = 1'b0;
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
        cyc(3);
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL idle_pause_ignored: got %0d want 0", state); end
    endtask

    task automatic test_start();
        diff_sel = 4'd5;
        score = 12'h123;
        press_start();
        n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL ready_entry_state: got %0d want 1", state); end
        n_cmp++; if (round_clr !== 1'b1) begin n_err++; $display("FAIL round_clr_high: got %b want 1", round_clr); end
        n_cmp++; if (ready_cnt !== 2'd3) begin n_err++; $display("FAIL ready_cnt_init: got %0d want 3", ready_cnt); end
        n_cmp++; if (time_left !== 8'h05) begin n_err++; $display("FAIL time_load: got %h want 05", time_left); end
        cyc(1);
        n_cmp++; if (round_clr !== 1'b0) begin n_err++; $display("FAIL round_clr_one_cycle: got %b want 0", round_clr); end
        cyc(2);
        n_cmp++; if (ready_cnt !== 2'd3) begin n_err++; $display("FAIL ready_cnt_r3: got %0d want 3", ready_cnt); end
        cyc(1);
        n_cmp++; if (ready_cnt !== 2'd2) begin n_err++; $display("FAIL ready_cnt_r4: got %0d want 2", ready_cnt); end
        cyc(4);
        n_cmp++; if (ready_cnt !== 2'd1) begin n_err++; $display("FAIL ready_cnt_r8: got %0d want 1", ready_cnt); end
        cyc(3);
        n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL still_ready_r11: got %0d want 1", state); end
        cyc(1);
        n_cmp++; if ({state, run, time_left, ready_cnt} !== {3'd2, 1'b1, 8'h05, 2'd0}) begin
            n_err++; $display("FAIL play_entry: got st=%0d run=%b tl=%h rc=%0d want st=2 run=1 tl=05 rc=0", state, run, time_left, ready_cnt); end
    endtask

    task automatic test_full_round();
        cyc(4);
        n_cmp++; if (time_left !== 8'h04) begin n_err++; $display("FAIL tl_04: got %h want 04", time_left); end
        cyc(4);
        n_cmp++; if (time_left !== 8'h03) begin n_err++; $display("FAIL tl_03: got %h want 03", time_left); end
        cyc(4);
        n_cmp++; if (time_left !== 8'h02) begin n_err++; $display("FAIL tl_02: got %h want 02", time_left); end
        cyc(4);
        n_cmp++; if (time_left !== 8'h01) begin n_err++; $display("FAIL tl_01: got %h want 01", time_left); end
        cyc(3);
        n_cmp++; if ({state, best} !== {3'd2, 12'h000}) begin
            n_err++; $display("FAIL pre_over: got st=%0d best=%h want st=2 best=000", state, best); end
        cyc(1);
        n_cmp++; if ({state, run, game_over, time_left, best} !== {3'd4, 1'b0, 1'b1, 8'h00, 12'h123}) begin
            n_err++; $display("FAIL over_entry: got st=%0d run=%b go=%b tl=%h best=%h want st=4 run=0 go=1 tl=00 best=123",
                              state, run, game_over, time_left, best); end
        score = 12'h099;
        press_start();
        cyc(32);
        n_cmp++; if ({state, best} !== {3'd4, 12'h123}) begin
            n_err++; $display("FAIL best_kept: got st=%0d best=%h want st=4 best=123", state, best); end
    endtask

    task automatic test_pause();
        press_start();
        cyc(12);
        cyc(9);
        n_cmp++; if (time_left !== 8'h03) begin n_err++; $display("FAIL pause_pre_tl: got %h want 03", time_left); end
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
        cyc(1);
        n_cmp++; if ({state, run, time_left} !== {3'd3, 1'b0, 8'h03}) begin
            n_err++; $display("FAIL pause_entry: got st=%0d run=%b tl=%h want st=3 run=0 tl=03", state, run, time_left); end
        cyc(24);
        n_cmp++; if ({state, run, time_left} !== {3'd3, 1'b0, 8'h03}) begin
            n_err++; $display("FAIL pause_frozen: got st=%0d run=%b tl=%h want st=3 run=0 tl=03", state, run, time_left); end
        cyc(24);
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
        n_cmp++; if (state !== 3'd3) begin n_err++; $display("FAIL pause_last: got %0d want 3", state); end
        cyc(1);
        n_cmp++; if ({state, run} !== {3'd2, 1'b1}) begin
            n_err++; $display("FAIL resume: got st=%0d run=%b want st=2 run=1", state, run); end
        cyc(8);
        n_cmp++; if ({state, time_left} !== {3'd2, 8'h01}) begin
            n_err++; $display("FAIL resume_pre_over: got st=%0d tl=%h want st=2 tl=01", state, time_left); end
        cyc(1);
        n_cmp++; if ({state, game_over} !== {3'd4, 1'b1}) begin
            n_err++; $display("FAIL pause_over_time: got st=%0d go=%b want st=4 go=1", state, game_over); end
    endtask

    task automatic test_ramp();
        diff_sel = 4'd13;
        press_start();
        cyc(12);
        n_cmp++; if (hrdn !== 4'd13) begin n_err++; $display("FAIL hrdn_base: got %0d want 13", hrdn); end
        diff_sel = 4'd2;
        cyc(8);
        n_cmp++; if (hrdn !== 4'd13) begin n_err++; $display("FAIL hrdn_p8: got %0d want 13", hrdn); end
        cyc(1);
        n_cmp++; if (hrdn !== 4'd14) begin n_err++; $display("FAIL hrdn_step: got %0d want 14", hrdn); end
        cyc(8);
        n_cmp++; if (hrdn !== 4'd15) begin n_err++; $display("FAIL hrdn_15: got %0d want 15", hrdn); end
        cyc(4);
        n_cmp++; if ({state, hrdn} !== {3'd4, 4'd15}) begin
            n_err++; $display("FAIL hrdn_hold: got st=%0d hrdn=%0d want st=4 hrdn=15", state, hrdn); end
    endtask

    task automatic test_back_to_back();
        diff_sel = 4'd15;
        press_start();
        cyc(12);
        cyc(5);
        n_cmp++; if (time_left !== 8'h04) begin n_err++; $display("FAIL restart_pre_tl: got %h want 04", time_left); end
        start = 1'b1;
        pause = 1'b1;
        cyc(1);
        start = 1'b0;
        pause = 1'b0;
        n_cmp++; if ({state, round_clr} !== {3'd2, 1'b0}) begin
            n_err++; $display("FAIL restart_edge_cyc: got st=%0d clr=%b want st=2 clr=0", state, round_clr); end
        cyc(1);
        n_cmp++; if ({state, round_clr, time_left, ready_cnt} !== {3'd1, 1'b1, 8'h05, 2'd3}) begin
            n_err++; $display("FAIL restart_ready: got st=%0d clr=%b tl=%h rc=%0d want st=1 clr=1 tl=05 rc=3",
                              state, round_clr, time_left, ready_cnt); end
        cyc(1);
        n_cmp++; if ({state, round_clr} !== {3'd1, 1'b0}) begin
            n_err++; $display("FAIL restart_clr_once: got st=%0d clr=%b want st=1 clr=0", state, round_clr); end
    endtask

    task automatic test_bcd_reset();
        cyc(11);
        n_cmp++; if ({state_12, time_left_12} !== {3'd2, 8'h12}) begin
            n_err++; $display("FAIL g12_play: got st=%0d tl=%h want st=2 tl=12", state_12, time_left_12); end
        cyc(11);
        n_cmp++; if (time_left_12 !== 8'h10) begin n_err++; $display("FAIL g12_tl10: got %h want 10", time_left_12); end
        n_cmp++; if (hrdn !== 4'd15) begin n_err++; $display("FAIL hrdn_sat: got %0d want 15", hrdn); end
        cyc(1);
        n_cmp++; if (time_left_12 !== 8'h09) begin n_err++; $display("FAIL bcd_borrow: got %h want 09", time_left_12); end
        cyc(2);
        n_cmp++; if ({state, best} !== {3'd2, 12'h123}) begin
            n_err++; $display("FAIL pre_async: got st=%0d best=%h want st=2 best=123", state, best); end
        clr_n = 1'b0;
        #1;
        n_cmp++; if ({state, best, run, time_left} !== {3'd0, 12'h000, 1'b0, 8'h00}) begin
            n_err++; $display("FAIL async_reset: got st=%0d best=%h run=%b tl=%h want all 0", state, best, run, time_left); end
        n_cmp++; if ({run_12, round_clr_12, hrdn_12, time_left_12, ready_cnt_12, game_over_12, best_12, state_12} !== 32'd0) begin
            n_err++; $display("FAIL async_reset_g12: got %h want 0",
                              {run_12, round_clr_12, hrdn_12, time_left_12, ready_cnt_12, game_over_12, best_12, state_12}); end
        #2;
        clr_n = 1'b1;
        cyc(2);
    endtask

    initial begin
        test_reset();
        test_start();
        test_full_round();
        test_pause();
        test_ramp();
        test_back_to_back();
        test_bcd_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
